// File: rtl/fetch_unit.sv
// Purpose  : instruction-fetch stage; loadable program memory walked by a pc, words issued to execute.
// Latency  : 1 cycle from FETCH to instr_valid; then 1 word/cycle; a taken jump costs a 1-cycle bubble.
// Backpress: instr_ready low with instr_valid high holds instruction, immediate_input and pc stable.
//
// Optional feature macro: FETCH_WRAP_EN
//   defined   -> pc wraps DEPTH-1 -> 0 and fetch runs forever (HALT never entered from ISSUE)
//   undefined -> a non-jump transfer of the word at DEPTH-1 halts the unit (pc reads 0 in HALT)
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset (memory is not cleared)
//   start                      begin execution at address 0; honoured in IDLE/HALT only
//   prog_we/prog_addr/prog_data program memory write port, active in every state
//   jump_en/jump_addr          redirect, sampled only on a transfer edge
//   instr_ready                execute stage accepts the presented word
//   instruction/immediate_input/instr_valid   presented word and its valid
//   pc                         address of the next word to be fetched
//   halted                     HALT state indicator
// DEPTH must equal 2**ADDR_W.

module fetch_unit #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int OP_W   = 4,
  parameter int IMM_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  prog_we,
  input  logic [ADDR_W-1:0]     prog_addr,
  input  logic [OP_W+IMM_W-1:0] prog_data,
  input  logic                  jump_en,
  input  logic [ADDR_W-1:0]     jump_addr,
  input  logic                  instr_ready,
  output logic [OP_W-1:0]       instruction,
  output logic [IMM_W-1:0]      immediate_input,
  output logic                  instr_valid,
  output logic [ADDR_W-1:0]     pc,
  output logic                  halted
);

  localparam int WORD_W = OP_W + IMM_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_word;
  logic              xfer;
  logic              end_of_prog;

  logic [ADDR_W-1:0] pc_nxt;
  logic              valid_nxt;
  logic              halted_nxt;
  logic              word_ld;

  // Combinational read; the write below is non-blocking, so a same-edge
  // write to the address being fetched hands out the old word.
  assign rd_word = mem[pc];
  assign xfer    = instr_valid & instr_ready;

  // In ISSUE pc already points one past the presented word, so pc==0 means
  // the presented word came from address DEPTH-1.
`ifdef FETCH_WRAP_EN
  assign end_of_prog = 1'b0;
`else
  assign end_of_prog = (pc == '0);
`endif

  // Program memory write port: no reset, active in every state.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (xfer) begin
          // A jump on the last word wins over end-of-program.
          if (jump_en)          state_nxt = S_FETCH;
          else if (end_of_prog) state_nxt = S_HALT;
        end
      end
      S_HALT:  if (start) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    pc_nxt     = pc;
    valid_nxt  = instr_valid;
    halted_nxt = halted;
    word_ld    = 1'b0;
    case (state)
      S_IDLE: begin
        valid_nxt = 1'b0;
        if (start) pc_nxt = '0;
      end
      S_FETCH: begin
        word_ld   = 1'b1;
        pc_nxt    = pc + ADDR_W'(1);
        valid_nxt = 1'b1;
      end
      S_ISSUE: begin
        if (xfer) begin
          if (jump_en) begin
            valid_nxt = 1'b0;
            pc_nxt    = jump_addr;
          end else if (end_of_prog) begin
            valid_nxt  = 1'b0;
            halted_nxt = 1'b1;
          end else begin
            word_ld = 1'b1;
            pc_nxt  = pc + ADDR_W'(1);
          end
        end
      end
      S_HALT: begin
        valid_nxt = 1'b0;
        if (start) begin
          halted_nxt = 1'b0;
          pc_nxt     = '0;
        end
      end
      default: valid_nxt = 1'b0;
    endcase
  end

  // Output / datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc              <= '0;
      instruction     <= '0;
      immediate_input <= '0;
      instr_valid     <= 1'b0;
      halted          <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      instr_valid <= valid_nxt;
      halted      <= halted_nxt;
      if (word_ld) begin
        instruction     <= rd_word[WORD_W-1 -: OP_W];
        immediate_input <= rd_word[IMM_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [11:0] prog_data;
  logic        jump_en;
  logic [3:0]  jump_addr;
  logic        instr_ready;
  logic [3:0]  instruction;
  logic [7:0]  immediate_input;
  logic        instr_valid;
  logic [3:0]  pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [11:0] mdl [16];
  logic [11:0] sb [$];

  fetch_unit #(.ADDR_W(4), .DEPTH(16), .OP_W(4), .IMM_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .jump_en(jump_en), .jump_addr(jump_addr), .instr_ready(instr_ready),
    .instruction(instruction), .immediate_input(immediate_input),
    .instr_valid(instr_valid), .pc(pc), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: a transfer happens on the next rising edge when valid&ready
  // are high (with reset released); compare against the oldest expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got %h_%h, expected no transfer", instruction, immediate_input);
      end else begin
        logic [11:0] exp_w;
        exp_w = sb.pop_front();
        if ({instruction, immediate_input} !== exp_w) begin
          errors++;
          $display("FAIL xfer_word: got %h_%h, expected %h", instruction, immediate_input, exp_w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", instr_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b, expected 0", halted); end
    checks++; if (pc !== 4'h0) begin errors++; $display("FAIL rst_pc: got %h, expected 0", pc); end
    checks++; if (instruction !== 4'h0) begin errors++; $display("FAIL rst_instr: got %h, expected 0", instruction); end
    checks++; if (immediate_input !== 8'h00) begin errors++; $display("FAIL rst_imm: got %h, expected 00", immediate_input); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_program();
    mdl[0] = 12'hC07; mdl[1] = 12'hD01; mdl[2] = 12'hE0F; mdl[3] = 12'h9F0;
    for (int i = 4; i < 16; i++) mdl[i] = {i[3:0], 8'hA0 + 8'(i)};
    for (int i = 0; i < 16; i++) begin
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = mdl[i];
      tick();
    end
    prog_we = 1'b0;
  endtask

  // Words 0..3 stream back to back; the last one jumps back to 0.
  task automatic test_stream();
    for (int i = 0; i < 4; i++) sb.push_back(mdl[i]);
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_fetch_valid: got %b, expected 0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid_rise: got %b, expected 1", instr_valid); end
    checks++; if (pc !== 4'h1) begin errors++; $display("FAIL stream_pc1: got %h, expected 1", pc); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_b2b_%0d: valid %b, expected 1", k, instr_valid); end
      if (k == 3) begin jump_en = 1'b1; jump_addr = 4'h0; end
      tick();
    end
    jump_en = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_bubble: got %b, expected 0", instr_valid); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL stream_drain: %0d left, expected 0", sb.size()); end
    instr_ready = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      start = (k == 1);
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instruction !== 4'hC || immediate_input !== 8'h07 || pc !== 4'h1) begin
        errors++;
        $display("FAIL stall_hold_%0d: got v=%b %h_%h pc=%h, expected v=1 C_07 pc=1",
                 k, instr_valid, instruction, immediate_input, pc);
      end
    end
    start = 1'b0;
    sb.push_back(mdl[0]);
    instr_ready = 1'b1;
    tick();
    checks++; if (instruction !== 4'hD || pc !== 4'h2) begin errors++; $display("FAIL stall_release: got %h pc=%h, expected D pc=2", instruction, pc); end
  endtask

  task automatic test_jump();
    sb.push_back(mdl[1]);
    tick();
    sb.push_back(mdl[2]);
    jump_en = 1'b1; jump_addr = 4'hA;
    tick();
    jump_en = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL jump_bubble: got %b, expected 0", instr_valid); end
    sb.push_back(mdl[10]);
    instr_ready = 1'b0;
    tick();
    checks++; if ({instruction, immediate_input} !== mdl[10] || pc !== 4'hB) begin errors++; $display("FAIL jump_target: got %h_%h pc=%h, expected %h pc=b", instruction, immediate_input, pc, mdl[10]); end
    // jump without a transfer must be ignored
    jump_en = 1'b1; jump_addr = 4'h3;
    tick();
    jump_en = 1'b0;
    checks++; if (pc !== 4'hB || instr_valid !== 1'b1) begin errors++; $display("FAIL jump_ignored: got pc=%h v=%b, expected pc=b v=1", pc, instr_valid); end
  endtask

  task automatic test_end_of_program();
    instr_ready = 1'b1;
`ifndef FETCH_WRAP_EN
    for (int i = 11; i < 16; i++) sb.push_back(mdl[i]);
    for (int k = 0; k < 6; k++) tick();
    checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || pc !== 4'h0) begin errors++; $display("FAIL halt_enter: got h=%b v=%b pc=%h, expected h=1 v=0 pc=0", halted, instr_valid, pc); end
    tick();
    tick();
    checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_stay: got h=%b v=%b, expected h=1 v=0", halted, instr_valid); end
    instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (halted !== 1'b0 || pc !== 4'h0) begin errors++; $display("FAIL halt_restart: got h=%b pc=%h, expected h=0 pc=0", halted, pc); end
    tick();
    checks++; if ({instruction, immediate_input} !== mdl[0] || pc !== 4'h1 || instr_valid !== 1'b1) begin errors++; $display("FAIL halt_reissue: got %h_%h pc=%h, expected %h pc=1", instruction, immediate_input, pc, mdl[0]); end
    sb.push_back(mdl[0]);
    instr_ready = 1'b1;
    tick();
`else
    for (int i = 11; i < 16; i++) sb.push_back(mdl[i]);
    sb.push_back(mdl[0]);
    for (int k = 0; k < 6; k++) tick();
    checks++; if (halted !== 1'b0 || instr_valid !== 1'b1 || {instruction, immediate_input} !== mdl[0] || pc !== 4'h1) begin errors++; $display("FAIL wrap_no_bubble: got h=%b v=%b %h_%h pc=%h, expected h=0 v=1 %h pc=1", halted, instr_valid, instruction, immediate_input, pc, mdl[0]); end
    tick();
`endif
    instr_ready = 1'b0;
    checks++; if ({instruction, immediate_input} !== mdl[1] || pc !== 4'h2) begin errors++; $display("FAIL eop_resume: got %h_%h pc=%h, expected %h pc=2", instruction, immediate_input, pc, mdl[1]); end
  endtask

  task automatic test_collision();
    logic [11:0] old_w;
    old_w = mdl[2];
    sb.push_back(mdl[1]);
    instr_ready = 1'b1;
    prog_we = 1'b1; prog_addr = 4'h2; prog_data = 12'h5A5;
    tick();
    prog_we = 1'b0;
    mdl[2] = 12'h5A5;
    checks++; if ({instruction, immediate_input} !== old_w) begin errors++; $display("FAIL coll_old: got %h_%h, expected %h", instruction, immediate_input, old_w); end
    sb.push_back(old_w);
    jump_en = 1'b1; jump_addr = 4'h2;
    tick();
    jump_en = 1'b0;
    instr_ready = 1'b0;
    tick();
    checks++; if ({instruction, immediate_input} !== 12'h5A5 || pc !== 4'h3) begin errors++; $display("FAIL coll_new: got %h_%h pc=%h, expected 5_a5 pc=3", instruction, immediate_input, pc); end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || halted !== 1'b0 || pc !== 4'h0 || instruction !== 4'h0 || immediate_input !== 8'h00) begin
      errors++;
      $display("FAIL midrst_outs: got v=%b h=%b pc=%h %h_%h, expected all 0",
               instr_valid, halted, pc, instruction, immediate_input);
    end
    tick();
    checks++; if (instr_valid !== 1'b0 || pc !== 4'h0) begin errors++; $display("FAIL midrst_idle: got v=%b pc=%h, expected v=0 pc=0", instr_valid, pc); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if ({instruction, immediate_input} !== mdl[0]) begin errors++; $display("FAIL midrst_mem0: got %h_%h, expected %h", instruction, immediate_input, mdl[0]); end
    sb.push_back(mdl[0]);
    instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 4'h2;
    tick();
    jump_en = 1'b0;
    instr_ready = 1'b0;
    tick();
    checks++; if ({instruction, immediate_input} !== mdl[2]) begin errors++; $display("FAIL midrst_mem2: got %h_%h, expected %h", instruction, immediate_input, mdl[2]); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    jump_en = 1'b0; jump_addr = '0; instr_ready = 1'b0;
    test_reset();
    load_program();
    test_stream();
    test_stall();
    test_jump();
    test_end_of_program();
    test_collision();
    test_reset_mid();
    tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_final: %0d words outstanding, expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
